full_duplex_uart_parity: RTL and testbench
==========================================

// Module: full_duplex_uart_parity
// PURPOSE
//  Two independent single-clock UART links with a parity bit, run concurrently (full duplex).
//  Side 1 serialises din1 and side 2 receives it on dout2/done2; side 2 serialises din2 and
//  side 1 receives it on dout1/done1. Both serial lines are internal, one bit per clk, no oversampling.
//  Used as a loopback serial-protocol block; host logic drives start/stop handshakes per side.
// PARAMETERS
//  DATA_W      8   payload bits per frame
//  PARITY_ODD  0   0 = even parity (parity bit = ^data), 1 = odd parity (~^data)
// PORTS
//  clk     in   1       single clock, rising edge
//  rst     in   1       reset, asynchronous and active-low (0 = reset)
//  start1  in   1       active-low launch request, side-1 transmitter (idle high)
//  stop1   in   1       active-high stop release, side-1 transmitter
//  start2  in   1       active-low launch request, side-2 transmitter
//  stop2   in   1       active-high stop release, side-2 transmitter
//  din1    in   DATA_W  payload sent side 1 -> side 2
//  din2    in   DATA_W  payload sent side 2 -> side 1
//  dout1   out  DATA_W  last good payload received by side 1 (from din2)
//  dout2   out  DATA_W  last good payload received by side 2 (from din1)
//  done1   out  1       side-1 receiver holds a valid frame
//  done2   out  1       side-2 receiver holds a valid frame
// BEHAVIOUR
//  Reset (rst=0, async): both TX in IDLE, serial lines = 1, dout1 = dout2 = 0, done1 = done2 = 0, counters 0.
//  TX FSM per link, registered line output, edge numbering from launch edge E0:
//   IDLE:   line = 1. At an edge with startN = 0: latch dinN, go to START.
//   START:  line = 0 during E0..E1.
//   DATA:   E1..E8 drive d[0]..d[7], LSB first.
//   PARITY: E9 drives the parity bit.
//   STOP:   from E10, line = 1. Hold while stopN = 0. On an edge with stopN = 1, go to IDLE.
//  din is sampled only at E0; later changes of din do not affect the frame in flight.
//  startN is level-sensitive in IDLE. If it is still low on the edge that returns to IDLE, no new frame starts
//   that edge. A new frame starts on the next edge where startN = 0 in IDLE (≥1 idle cycle between frames).
//  startN and stopN are ignored in every state other than those stated above.
//  RX FSM per link, sampling the TX line each edge:
//   IDLE:  line = 0 seen -> RCV, and clear doneN.
//   RCV:   shift 8 bits LSB first, then take the parity bit, then check the stop bit.
//   Stop check at E11: if stop = 1 and parity matches, dout <= payload and done <= 1 in the same edge.
//    Otherwise dout is unchanged and done stays 0.
//   doneN is a level. It stays 1 until the next start bit on that link or reset.
//  Latency: start sampled low at E0 -> doneN high after E11, independent of stopN timing.
//  Links are fully independent. Simultaneous launches on both sides complete in the same cycles.
//  Reset mid-frame aborts both directions immediately and outputs return to reset values.
// STRUCTURE
//  Package uart_parity_pkg: DATA_W default, TX/RX state enums (IDLE, START, DATA, PARITY, STOP), parity function.
//  Sub-module uart_parity_link (tx FSM + internal line + rx FSM, one direction), instantiated twice:
//   din1 -> dout2/done2 and din2 -> dout1/done1.
// TESTING
//  1. Reset: rst = 0 with random inputs -> dout1 = dout2 = 0, done1 = done2 = 0, lines high.
//  2. Duplex: din1 = 8'hC1, din2 = 8'h81, start1 = start2 = 0 for 1 cycle, stop held high
//     -> after E11, dout2 = 8'hC1, dout1 = 8'h81, done1 = done2 = 1.
//  3. Stop hold: stop1 = 0 until E15 -> done2 still rises at E11; TX1 stays in STOP until E15 (stop1 = 1);
//     a start1 pulse before that is ignored.
//  4. Parity: force link line bit inverted at the parity slot -> done2 stays 0, dout2 keeps its prior value;
//     PARITY_ODD = 1 build passes the clean 8'h00 frame.
//  5. Back-to-back: 8'hAA then 8'h55 on side 2 -> done1 drops at second start bit, then dout1 = 8'h55.
//  6. Abort: rst = 0 at E5 -> all outputs 0 immediately; the next clean frame 8'h3C is received correctly.

Source files
------------

// File: rtl/uart_parity_pkg.sv
// Shared types and helpers for the parity UART links.
package uart_parity_pkg;

  localparam int DATA_W_DEF = 8;
  // Widest payload the parity helper accepts; narrower payloads are zero-extended.
  localparam int PAR_MAX_W  = 64;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Parity bit for a payload: even parity is the XOR of all bits, odd is its inverse.
  // Zero extension does not change the XOR, so callers may pass any width up to PAR_MAX_W.
  function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] d, input logic odd);
    return odd ^ (^d);
  endfunction

endpackage

// File: rtl/uart_parity_link.sv
// One direction of the duplex pair: transmitter FSM, internal serial line, receiver FSM.
// Frame on the line: start(0), DATA_W bits LSB first, parity, stop(1), one bit per clk.
module uart_parity_link
  import uart_parity_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);

  logic              line;

  tx_state_e         tx_st;
  logic [DATA_W-1:0] tx_sr;
  logic              tx_par;
  logic [CW-1:0]     tx_cnt;

  rx_state_e         rx_st;
  logic [DATA_W-1:0] rx_sr;
  logic              rx_par;
  logic [CW-1:0]     rx_cnt;

  // Transmitter: payload and its parity are captured at launch; line is a registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st  <= TX_IDLE;
      line   <= 1'b1;
      tx_sr  <= '0;
      tx_par <= 1'b0;
      tx_cnt <= '0;
    end else begin
      case (tx_st)
        TX_IDLE: begin
          line <= 1'b1;
          if (!start) begin
            tx_sr  <= din;
            tx_par <= parity_bit(PAR_MAX_W'(din), PARITY_ODD);
            line   <= 1'b0;
            tx_st  <= TX_START;
          end
        end
        TX_START: begin
          line   <= tx_sr[0];
          tx_sr  <= tx_sr >> 1;
          tx_cnt <= CW'(1);
          tx_st  <= TX_DATA;
        end
        TX_DATA: begin
          // tx_cnt counts bits already placed on the line
          if (tx_cnt == CW'(DATA_W)) begin
            line  <= tx_par;
            tx_st <= TX_PARITY;
          end else begin
            line   <= tx_sr[0];
            tx_sr  <= tx_sr >> 1;
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_PARITY: begin
          line  <= 1'b1;
          tx_st <= TX_STOP;
        end
        TX_STOP: begin
          // stop level is held as long as the host keeps stop low
          line <= 1'b1;
          if (stop) tx_st <= TX_IDLE;
        end
        default: begin
          line  <= 1'b1;
          tx_st <= TX_IDLE;
        end
      endcase
    end
  end

  // Receiver: detects the start bit, shifts data, checks parity and stop, publishes good frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st  <= RX_IDLE;
      rx_sr  <= '0;
      rx_par <= 1'b0;
      rx_cnt <= '0;
      dout   <= '0;
      done   <= 1'b0;
    end else begin
      case (rx_st)
        RX_IDLE: begin
          if (!line) begin
            done   <= 1'b0;
            rx_cnt <= '0;
            rx_st  <= RX_DATA;
          end
        end
        RX_DATA: begin
          rx_sr  <= {line, rx_sr[DATA_W-1:1]};
          rx_cnt <= rx_cnt + 1'b1;
          if (rx_cnt == CW'(DATA_W - 1)) rx_st <= RX_PARITY;
        end
        RX_PARITY: begin
          rx_par <= line;
          rx_st  <= RX_STOP;
        end
        RX_STOP: begin
          // a bad frame leaves dout untouched and done low
          if (line && (rx_par == parity_bit(PAR_MAX_W'(rx_sr), PARITY_ODD))) begin
            dout <= rx_sr;
            done <= 1'b1;
          end
          rx_st <= RX_IDLE;
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/full_duplex_uart_parity.sv
// Full-duplex pair of parity UART links: side 1 -> side 2 and side 2 -> side 1.
module full_duplex_uart_parity
  import uart_parity_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start1,
  input  logic              stop1,
  input  logic              start2,
  input  logic              stop2,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  output logic [DATA_W-1:0] dout1,
  output logic [DATA_W-1:0] dout2,
  output logic              done1,
  output logic              done2
);

  // Lane i carries the transmit side i+1; its receiver output belongs to the other side.
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]             start_v;
  logic [NUM_LANES-1:0]             stop_v;
  logic [NUM_LANES-1:0]             done_v;
  logic [NUM_LANES-1:0][DATA_W-1:0] din_v;
  logic [NUM_LANES-1:0][DATA_W-1:0] dout_v;

  assign start_v = {start2, start1};
  assign stop_v  = {stop2, stop1};
  assign din_v   = {din2, din1};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_link
    uart_parity_link #(
      .DATA_W    (DATA_W),
      .PARITY_ODD(PARITY_ODD)
    ) u_link (
      .clk  (clk),
      .rst  (rst),
      .start(start_v[i]),
      .stop (stop_v[i]),
      .din  (din_v[i]),
      .dout (dout_v[i]),
      .done (done_v[i])
    );
  end

  assign dout2 = dout_v[0];
  assign done2 = done_v[0];
  assign dout1 = dout_v[1];
  assign done1 = done_v[1];

endmodule

// File: tb/tb_full_duplex_uart_parity.sv
// Self-checking bench for full_duplex_uart_parity (even build plus an odd-parity build).
module tb_full_duplex_uart_parity;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start1, stop1, start2, stop2;
  logic [W-1:0] din1, din2;
  logic [W-1:0] dout1, dout2, o_dout1, o_dout2;
  logic         done1, done2, o_done1, o_done2;
  logic         fv;

  int n_chk  = 0;
  int n_pass = 0;

  // model of what each receiver should be holding
  logic [W-1:0] exp_dout1 = '0;
  logic [W-1:0] exp_dout2 = '0;

  full_duplex_uart_parity #(.DATA_W(W), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .start1(start1), .stop1(stop1), .start2(start2), .stop2(stop2),
    .din1(din1), .din2(din2), .dout1(dout1), .dout2(dout2), .done1(done1), .done2(done2));

  full_duplex_uart_parity #(.DATA_W(W), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .start1(start1), .stop1(stop1), .start2(start2), .stop2(stop2),
    .din1(din1), .din2(din2), .dout1(o_dout1), .dout2(o_dout2), .done1(o_done1), .done2(o_done2));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // parity bit the transmitter must send, from a count of ones
  function automatic bit ref_par(input logic [W-1:0] d, input bit odd);
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++) if (d[i]) ones++;
    return ((ones % 2) == 1) ^ odd;
  endfunction

  // advance one edge; inputs are driven and outputs sampled at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start1 = 1'($urandom); start2 = 1'($urandom);
      stop1  = 1'($urandom); stop2  = 1'($urandom);
      din1   = W'($urandom); din2   = W'($urandom);
      tick();
    end
    n_chk++; if (dout1 !== '0) $display("FAIL reset_dout1 got %h want 00", dout1); else n_pass++;
    n_chk++; if (dout2 !== '0) $display("FAIL reset_dout2 got %h want 00", dout2); else n_pass++;
    n_chk++; if (done1 !== 1'b0) $display("FAIL reset_done1 got %b want 0", done1); else n_pass++;
    n_chk++; if (done2 !== 1'b0) $display("FAIL reset_done2 got %b want 0", done2); else n_pass++;
    n_chk++; if (dut.g_link[0].u_link.line !== 1'b1) $display("FAIL reset_line12 got %b want 1", dut.g_link[0].u_link.line); else n_pass++;
    n_chk++; if (dut.g_link[1].u_link.line !== 1'b1) $display("FAIL reset_line21 got %b want 1", dut.g_link[1].u_link.line); else n_pass++;
    start1 = 1'b1; start2 = 1'b1; stop1 = 1'b1; stop2 = 1'b1;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_duplex();
    din1 = 8'hC1; din2 = 8'h81; stop1 = 1'b1; stop2 = 1'b1;
    start1 = 1'b0; start2 = 1'b0;
    tick();                               // E0
    start1 = 1'b1; start2 = 1'b1;
    din1 = W'($urandom); din2 = W'($urandom);   // must not affect the frames in flight
    repeat (10) tick();                   // after E10
    n_chk++; if (done1 !== 1'b0) $display("FAIL duplex_done1_e10 got %b want 0", done1); else n_pass++;
    n_chk++; if (done2 !== 1'b0) $display("FAIL duplex_done2_e10 got %b want 0", done2); else n_pass++;
    tick();                               // after E11
    exp_dout2 = 8'hC1; exp_dout1 = 8'h81;
    n_chk++; if (dout2 !== exp_dout2) $display("FAIL duplex_dout2 got %h want %h", dout2, exp_dout2); else n_pass++;
    n_chk++; if (dout1 !== exp_dout1) $display("FAIL duplex_dout1 got %h want %h", dout1, exp_dout1); else n_pass++;
    n_chk++; if (done1 !== 1'b1) $display("FAIL duplex_done1 got %b want 1", done1); else n_pass++;
    n_chk++; if (done2 !== 1'b1) $display("FAIL duplex_done2 got %b want 1", done2); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_stop_hold();
    logic [W-1:0] r;
    r = W'($urandom);
    din1 = r; stop1 = 1'b0; start1 = 1'b0;
    tick();                               // E0
    start1 = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      if (e == 13) start1 = 1'b0;         // low at E13, must be ignored in STOP
      if (e == 14) start1 = 1'b1;
      if (e == 15) stop1  = 1'b1;         // release sampled at E15
      tick();                             // after edge e
      if (e == 10) begin
        n_chk++; if (done2 !== 1'b0) $display("FAIL stophold_done2_e10 got %b want 0", done2); else n_pass++;
      end
      if (e == 11) begin
        exp_dout2 = r;
        n_chk++; if (done2 !== 1'b1) $display("FAIL stophold_done2_e11 got %b want 1", done2); else n_pass++;
        n_chk++; if (dout2 !== exp_dout2) $display("FAIL stophold_dout2 got %h want %h", dout2, exp_dout2); else n_pass++;
      end
      if (e == 14) begin
        n_chk++; if (dut.g_link[0].u_link.line !== 1'b1) $display("FAIL stophold_line_e14 got %b want 1", dut.g_link[0].u_link.line); else n_pass++;
      end
    end
    n_chk++; if (done2 !== 1'b1) $display("FAIL stophold_no_restart got %b want 1", done2); else n_pass++;
    n_chk++; if (dout2 !== exp_dout2) $display("FAIL stophold_dout2_end got %h want %h", dout2, exp_dout2); else n_pass++;
  endtask

  task automatic test_parity();
    logic [W-1:0] x;
    x = W'($urandom);
    if (ref_par(x, 1'b0)) x[0] = ~x[0];  // even payload: corrupted parity slot becomes 1
    din1 = x; stop1 = 1'b1; start1 = 1'b0;
    tick();                               // E0
    start1 = 1'b1;
    repeat (9) tick();                    // after E9: parity slot on the line
    n_chk++; if (dut.g_link[0].u_link.line !== ref_par(x, 1'b0)) $display("FAIL parity_slot got %b want %b", dut.g_link[0].u_link.line, ref_par(x, 1'b0)); else n_pass++;
    fv = ~ref_par(x, 1'b0);
    force dut.g_link[0].u_link.line = fv;
    tick();                               // after E10
    release dut.g_link[0].u_link.line;
    tick();                               // after E11
    n_chk++; if (done2 !== 1'b0) $display("FAIL parity_bad_done2 got %b want 0", done2); else n_pass++;
    n_chk++; if (dout2 !== exp_dout2) $display("FAIL parity_bad_dout2 got %h want %h", dout2, exp_dout2); else n_pass++;
    n_chk++; if (o_done2 !== 1'b1) $display("FAIL odd_clean_done2 got %b want 1", o_done2); else n_pass++;
    n_chk++; if (o_dout2 !== x) $display("FAIL odd_clean_dout2 got %h want %h", o_dout2, x); else n_pass++;
    repeat (2) tick();
    // clean all-zero frame both ways, odd build
    din1 = '0; din2 = '0; start1 = 1'b0; start2 = 1'b0; stop2 = 1'b1;
    tick();
    start1 = 1'b1; start2 = 1'b1;
    repeat (10) tick();
    n_chk++; if (o_done1 !== 1'b0) $display("FAIL odd_zero_done1_e10 got %b want 0", o_done1); else n_pass++;
    tick();
    exp_dout1 = '0; exp_dout2 = '0;
    n_chk++; if (o_done1 !== 1'b1) $display("FAIL odd_zero_done1 got %b want 1", o_done1); else n_pass++;
    n_chk++; if (o_done2 !== 1'b1) $display("FAIL odd_zero_done2 got %b want 1", o_done2); else n_pass++;
    n_chk++; if (o_dout1 !== '0) $display("FAIL odd_zero_dout1 got %h want 00", o_dout1); else n_pass++;
    n_chk++; if (done2 !== 1'b1) $display("FAIL even_zero_done2 got %b want 1", done2); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    din2 = 8'hAA; stop2 = 1'b1; start2 = 1'b0;
    tick();                               // E0 (start2 stays low)
    din2 = 8'h55;
    repeat (11) tick();                   // after E11
    exp_dout1 = 8'hAA;
    n_chk++; if (done1 !== 1'b1) $display("FAIL b2b_done1_first got %b want 1", done1); else n_pass++;
    n_chk++; if (dout1 !== exp_dout1) $display("FAIL b2b_dout1_first got %h want %h", dout1, exp_dout1); else n_pass++;
    tick();                               // after E12: second launch
    start2 = 1'b1;
    n_chk++; if (done1 !== 1'b1) $display("FAIL b2b_done1_e12 got %b want 1", done1); else n_pass++;
    tick();                               // after E13: start bit seen
    n_chk++; if (done1 !== 1'b0) $display("FAIL b2b_done1_drop got %b want 0", done1); else n_pass++;
    n_chk++; if (dout1 !== exp_dout1) $display("FAIL b2b_dout1_hold got %h want %h", dout1, exp_dout1); else n_pass++;
    repeat (9) tick();                    // after E22
    n_chk++; if (done1 !== 1'b0) $display("FAIL b2b_done1_e22 got %b want 0", done1); else n_pass++;
    tick();                               // after E23
    exp_dout1 = 8'h55;
    n_chk++; if (done1 !== 1'b1) $display("FAIL b2b_done1_second got %b want 1", done1); else n_pass++;
    n_chk++; if (dout1 !== exp_dout1) $display("FAIL b2b_dout1_second got %h want %h", dout1, exp_dout1); else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_abort();
    logic [W-1:0] y;
    din1 = W'($urandom); din2 = W'($urandom);
    stop1 = 1'b1; stop2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
    tick();
    start1 = 1'b1; start2 = 1'b1;
    repeat (5) tick();                    // after E5
    rst = 1'b0;
    #1;
    exp_dout1 = '0; exp_dout2 = '0;
    n_chk++; if (dout1 !== '0) $display("FAIL abort_dout1 got %h want 00", dout1); else n_pass++;
    n_chk++; if (dout2 !== '0) $display("FAIL abort_dout2 got %h want 00", dout2); else n_pass++;
    n_chk++; if ({done1, done2} !== 2'b00) $display("FAIL abort_done got %b want 00", {done1, done2}); else n_pass++;
    n_chk++; if (dut.g_link[0].u_link.line !== 1'b1) $display("FAIL abort_line12 got %b want 1", dut.g_link[0].u_link.line); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    tick();
    y = W'($urandom);
    din1 = 8'h3C; din2 = y; start1 = 1'b0; start2 = 1'b0;
    tick();
    start1 = 1'b1; start2 = 1'b1;
    repeat (11) tick();
    exp_dout2 = 8'h3C; exp_dout1 = y;
    n_chk++; if (dout2 !== exp_dout2) $display("FAIL abort_next_dout2 got %h want %h", dout2, exp_dout2); else n_pass++;
    n_chk++; if (dout1 !== exp_dout1) $display("FAIL abort_next_dout1 got %h want %h", dout1, exp_dout1); else n_pass++;
    n_chk++; if ({done1, done2} !== 2'b11) $display("FAIL abort_next_done got %b want 11", {done1, done2}); else n_pass++;
    repeat (2) tick();
  endtask

  // random payloads, random stop-hold lengths and ignored start requests during STOP
  task automatic test_random();
    logic [W-1:0] d1, d2;
    int r1, r2;
    for (int it = 0; it < 12; it++) begin
      d1 = W'($urandom); d2 = W'($urandom);
      r1 = 11 + int'($urandom_range(0, 4));
      r2 = 11 + int'($urandom_range(0, 4));
      din1 = d1; din2 = d2; start1 = 1'b0; start2 = 1'b0; stop1 = 1'b0; stop2 = 1'b0;
      tick();                             // E0
      for (int e = 1; e <= 16; e++) begin
        din1 = W'($urandom); din2 = W'($urandom);
        stop1  = (e >= r1);
        stop2  = (e >= r2);
        start1 = !(e >= 12 && e <= r1);
        start2 = !(e >= 12 && e <= r2);
        tick();                           // after edge e
        if (e == 11) begin
          exp_dout2 = d1; exp_dout1 = d2;
          n_chk++; if (dout2 !== exp_dout2) $display("FAIL rand%0d_dout2 got %h want %h", it, dout2, exp_dout2); else n_pass++;
          n_chk++; if (dout1 !== exp_dout1) $display("FAIL rand%0d_dout1 got %h want %h", it, dout1, exp_dout1); else n_pass++;
          n_chk++; if ({done1, done2} !== 2'b11) $display("FAIL rand%0d_done got %b want 11", it, {done1, done2}); else n_pass++;
        end
      end
      n_chk++; if ({done1, done2} !== 2'b11) $display("FAIL rand%0d_hold got %b want 11", it, {done1, done2}); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0;
    start1 = 1'b1; start2 = 1'b1; stop1 = 1'b1; stop2 = 1'b1;
    din1 = '0; din2 = '0; fv = 1'b0;
    @(negedge clk);
    test_reset();
    test_duplex();
    test_stop_hold();
    test_parity();
    test_back_to_back();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
